// File: rtl/tag_verify.sv
// rtl/tag_verify.sv - constant-time comparison of squeezed tag words against the received tag
// Plaintext is released only when every tag word matches; otherwise it is zeroized.
module tag_verify #(
   parameter int TAG_WIDTH  = 128,
   parameter int WWIDTH     = 32,
   parameter int PTEXT_SIZE = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [TAG_WIDTH-1:0]  tag_in,
   input  logic [PTEXT_SIZE-1:0] ptext_in,
   input  logic                  sq_valid,
   input  logic [WWIDTH-1:0]     sq_data,
   output logic                  sq_ready,
   output logic                  busy,
   output logic [PTEXT_SIZE-1:0] ptextd,
   output logic                  squeezDone,
   output logic                  failure
);

   localparam int NWORDS = TAG_WIDTH / WWIDTH;
   localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
   localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

   typedef enum logic [1:0] {IDLE, COMPARE, RESULT} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt;
   logic [WWIDTH-1:0]       diff;
   logic [TAG_WIDTH-1:0]    tag_r;
   logic [PTEXT_SIZE-1:0]   ptext_r;
   logic [WWIDTH-1:0]       cur_word;
   logic                    handshake;

   always_comb begin
      cur_word = '0;
      for (int i = 0; i < NWORDS; i++) begin
         if (cnt == CW'(i)) cur_word = tag_r[i*WWIDTH +: WWIDTH];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // The exit from COMPARE depends only on the word count, never on the data.
   always_comb begin
      state_d   = state_q;
      sq_ready  = 1'b0;
      busy      = 1'b1;
      handshake = 1'b0;
      case (state_q)
         IDLE: begin
            busy = 1'b0;
            if (start) state_d = COMPARE;
         end
         COMPARE: begin
            sq_ready  = 1'b1;
            handshake = sq_valid;
            if (sq_valid && cnt == LAST) state_d = RESULT;
         end
         RESULT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         diff       <= '0;
         tag_r      <= '0;
         ptext_r    <= '0;
         ptextd     <= '0;
         failure    <= 1'b0;
         squeezDone <= 1'b0;
      end else begin
         squeezDone <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  tag_r   <= tag_in;
                  ptext_r <= ptext_in;
                  diff    <= '0;
                  cnt     <= '0;
                  ptextd  <= '0;
                  failure <= 1'b0;
               end
            end
            COMPARE: begin
               if (handshake) begin
                  diff <= diff | (sq_data ^ cur_word);
                  cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
               end
            end
            RESULT: begin
               squeezDone <= 1'b1;
               failure    <= (diff != '0);
               ptextd     <= (diff == '0) ? ptext_r : '0;
            end
            default: ;
         endcase
      end
   end

endmodule
